// File: rtl/calc_bcd_pkg.sv
// Shared types and constants for the calculator BCD-to-binary path.
package calc_bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SUB3_THRESH = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Smallest width that holds every value below 10**digits.
  function automatic int bin_width(input int digits);
    longint p;
    int     w;
    p = 64'sd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'sd10;
    end
    w = 0;
    for (int b = 0; b < 63; b++) begin
      if ((64'sd1 << b) < p) begin
        w = b + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Reverse double-dabble correction cell: a digit field that reached 8..12 after a
// right shift is pulled back by 3 so it again holds a legal BCD digit.
module bcd_sub3
  import calc_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= SUB3_THRESH) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter, one result bit per clock, start/busy/done handshake.
// Optional digit validity check enabled by defining CALC_BCD_CHECK_EN.
module bcd_to_bin_seq
  import calc_bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  state_t             state_r;
  logic [WORK_W-1:0]  work_r;
  logic [WORK_W-1:0]  shifted_s;
  logic [WORK_W-1:0]  next_work_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [BIN_W-1:0]   bin_out_r;
  logic               err_r;
  logic               last_iter_s;

`ifdef CALC_BCD_CHECK_EN
  logic               invalid_r;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction
`endif

  // The binary result accumulates LSB-first in the low BIN_W bits; digit fields sit above.
  assign shifted_s = {1'b0, work_r[WORK_W-1:1]};
  assign next_work_s[BIN_W-1:0] = shifted_s[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_sub3 u_sub3 (
      .din  (shifted_s[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .dout (next_work_s[BIN_W + g*DIGIT_W +: DIGIT_W])
    );
  end

  assign last_iter_s = (cnt_r == CNT_W'(BIN_W - 1));

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      work_r    <= '0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bin_out_r <= '0;
      err_r     <= 1'b0;
`ifdef CALC_BCD_CHECK_EN
      invalid_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            work_r  <= {bcd_in, {BIN_W{1'b0}}};
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
`ifdef CALC_BCD_CHECK_EN
            invalid_r <= has_bad_digit(bcd_in);
`endif
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work_r <= next_work_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_iter_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
`ifdef CALC_BCD_CHECK_EN
            bin_out_r <= invalid_r ? {BIN_W{1'b0}} : next_work_s[BIN_W-1:0];
            err_r     <= invalid_r;
`else
            bin_out_r <= next_work_s[BIN_W-1:0];
            err_r     <= 1'b0;
`endif
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign bin_out = bin_out_r;
  assign err     = err_r;

endmodule
